// File: rtl/vga_timing_overlay_if.sv
// vga_timing_overlay_if: status-box control inputs and VGA pin outputs of the overlay generator.
interface vga_timing_overlay_if #(parameter int CW = 4, parameter int XW = 10, parameter int YW = 10);
    logic          alert;
    logic          blink_en;
    logic [XW-1:0] box_x0;
    logic [XW-1:0] box_x1;
    logic [YW-1:0] box_y0;
    logic [YW-1:0] box_y1;
    logic          o_hsync;
    logic          o_vsync;
    logic [CW-1:0] o_red;
    logic [CW-1:0] o_green;
    logic [CW-1:0] o_blue;
    logic          o_active;
    logic          o_frame_start;
    modport master(output alert, blink_en, box_x0, box_x1, box_y0, box_y1,
                   input o_hsync, o_vsync, o_red, o_green, o_blue, o_active, o_frame_start);
    modport slave(input alert, blink_en, box_x0, box_x1, box_y0, box_y1,
                  output o_hsync, o_vsync, o_red, o_green, o_blue, o_active, o_frame_start);
endinterface

// File: rtl/vga_timing_overlay.sv
// vga_timing_overlay: parametrised VGA timing with a frame-latched status box that can blink on alert.
module vga_timing_overlay #(
    parameter int              CW           = 4,
    parameter int              DIV          = 2,
    parameter int              H_ACT        = 640,
    parameter int              H_FP         = 16,
    parameter int              H_SYNC       = 96,
    parameter int              H_BP         = 48,
    parameter int              V_ACT        = 480,
    parameter int              V_FP         = 10,
    parameter int              V_SYNC       = 2,
    parameter int              V_BP         = 33,
    parameter bit              HS_POL       = 1'b0,
    parameter bit              VS_POL       = 1'b0,
    parameter int              XW           = 10,
    parameter int              YW           = 10,
    parameter logic [3*CW-1:0] OK_RGB       = 12'h0F0,
    parameter logic [3*CW-1:0] ALERT_RGB    = 12'hF00,
    parameter logic [3*CW-1:0] BG_RGB       = 12'h000,
    parameter int              BLINK_FRAMES = 30
) (
    input logic                  clk,
    input logic                  reset_n,
    vga_timing_overlay_if.slave  bus
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DW    = DIV > 1 ? $clog2(DIV) : 1;
    localparam int FW    = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    typedef enum logic {HIDE = 1'b0, SHOW = 1'b1} state_t;
    logic [DW-1:0]   r_div;
    logic [XW-1:0]   r_h, r_x0, r_x1, w_x0, w_x1;
    logic [YW-1:0]   r_v, r_y0, r_y1, w_y0, w_y1;
    logic            r_alert, r_blink, w_alert, w_blink;
    logic            w_tick, w_h_end, w_v_end, w_fs, w_act, w_in, w_hs_on, w_vs_on;
    state_t          r_state, w_state_nx;
    logic [FW-1:0]   r_fcnt, w_fcnt_nx;
    logic            r_hs, r_vs, r_act, r_fs;
    logic [3*CW-1:0] r_rgb, w_rgb;
    assign w_tick  = r_div == DW'(DIV - 1);
    assign w_h_end = r_h == XW'(H_TOT - 1);
    assign w_v_end = r_v == YW'(V_TOT - 1);
    assign w_fs    = w_tick && r_h == '0 && r_v == '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_h <= w_h_end ? '0 : r_h + 1'b1;
                if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
            end
        end
    end
    // Frame-start pixel already uses the values being latched, so a frame never mixes settings.
    assign w_x0    = w_fs ? bus.box_x0 : r_x0;
    assign w_x1    = w_fs ? bus.box_x1 : r_x1;
    assign w_y0    = w_fs ? bus.box_y0 : r_y0;
    assign w_y1    = w_fs ? bus.box_y1 : r_y1;
    assign w_alert = w_fs ? bus.alert : r_alert;
    assign w_blink = w_fs ? bus.blink_en : r_blink;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_alert <= 1'b0;
            r_blink <= 1'b0;
            r_state <= SHOW;
            r_fcnt  <= '0;
        end else begin
            if (w_fs) begin
                r_x0    <= bus.box_x0;
                r_x1    <= bus.box_x1;
                r_y0    <= bus.box_y0;
                r_y1    <= bus.box_y1;
                r_alert <= bus.alert;
                r_blink <= bus.blink_en;
            end
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
        end
    end
    // A fresh alert restarts the blink in the visible phase.
    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        if (w_fs) begin
            if (bus.alert && !r_alert) begin
                w_state_nx = SHOW;
                w_fcnt_nx  = '0;
            end else if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                w_state_nx = r_state == SHOW ? HIDE : SHOW;
                w_fcnt_nx  = '0;
            end else begin
                w_fcnt_nx = r_fcnt + 1'b1;
            end
        end
    end
    assign w_act   = r_h < XW'(H_ACT) && r_v < YW'(V_ACT);
    assign w_hs_on = r_h >= XW'(H_ACT + H_FP) && r_h < XW'(H_ACT + H_FP + H_SYNC);
    assign w_vs_on = r_v >= YW'(V_ACT + V_FP) && r_v < YW'(V_ACT + V_FP + V_SYNC);
    assign w_in    = r_h >= w_x0 && r_h < w_x1 && r_v >= w_y0 && r_v < w_y1;
    assign w_rgb   = !w_act ? '0 : !w_in ? BG_RGB : !w_alert ? OK_RGB :
                     (!w_blink || w_state_nx == SHOW) ? ALERT_RGB : BG_RGB;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs  <= !HS_POL;
            r_vs  <= !VS_POL;
            r_act <= 1'b0;
            r_rgb <= '0;
            r_fs  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_hs  <= w_hs_on ? HS_POL : !HS_POL;
                r_vs  <= w_vs_on ? VS_POL : !VS_POL;
                r_act <= w_act;
                r_rgb <= w_rgb;
            end
            r_fs <= w_fs;
        end
    end
    assign bus.o_hsync       = r_hs;
    assign bus.o_vsync       = r_vs;
    assign bus.o_active      = r_act;
    assign bus.o_frame_start = r_fs;
    assign bus.o_red         = r_rgb[3*CW-1:2*CW];
    assign bus.o_green       = r_rgb[2*CW-1:CW];
    assign bus.o_blue        = r_rgb[CW-1:0];
endmodule

// File: tb/tb_vga_timing_overlay.sv
// tb_vga_timing_overlay: directed checks of a small-timing DIV=2 instance and an inverted-polarity DIV=1 instance.
module tb_vga_timing_overlay;
    localparam int CW = 4, XW = 4, YW = 4;
    localparam int F1 = 196;
    logic clk = 1'b0;
    logic rst1_n = 1'b0, rst2_n = 1'b0;
    int n_chk = 0, n_pass = 0;
    logic [11:0] c_rgb [F1];
    logic        c_hs [F1], c_vs [F1], c_act [F1], c_fs [F1];
    logic [11:0] d_rgb [98];
    logic        d_hs [98], d_vs [98];
    int exp_px [7] = '{12'h0F0, 12'hF00, 12'hF00, 12'h000, 12'h000, 12'hF00, 12'h000};
    int exp_nz [7] = '{12, 12, 12, 0, 0, 12, 0};
    always #5 clk = ~clk;
    vga_timing_overlay_if #(.CW(CW), .XW(XW), .YW(YW)) b1 ();
    vga_timing_overlay_if #(.CW(CW), .XW(XW), .YW(YW)) b2 ();
    vga_timing_overlay #(.CW(CW), .DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .XW(XW), .YW(YW), .BLINK_FRAMES(2))
        u1 (.clk(clk), .reset_n(rst1_n), .bus(b1));
    vga_timing_overlay #(.CW(CW), .DIV(1), .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
        .XW(XW), .YW(YW), .BLINK_FRAMES(2))
        u2 (.clk(clk), .reset_n(rst2_n), .bus(b2));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic int k1(input int x, input int y);
        return 2 * (y * 14 + x);
    endfunction
    task automatic wait_fs(input bit which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? b2.o_frame_start : b1.o_frame_start) && n < 500);
        if (n >= 500) check("fs_timeout", 0, 1);
    endtask
    task automatic capture(input int fi);
        for (int k = 0; k < F1; k++) begin
            if (k > 0) @(negedge clk);
            c_rgb[k] = {b1.o_red, b1.o_green, b1.o_blue};
            c_hs[k]  = b1.o_hsync;
            c_vs[k]  = b1.o_vsync;
            c_act[k] = b1.o_active;
            c_fs[k]  = b1.o_frame_start;
            if (fi == 0 && k == 20) begin
                b1.alert    = 1'b1;
                b1.blink_en = 1'b1;
            end
            if (fi == 5 && k == 100) b1.box_x1 = 4'd2;
        end
    endtask
    initial begin
        int gap, nz, hsl, vsl, na, nf, bad;
        b1.alert = 1'b0; b1.blink_en = 1'b0;
        b1.box_x0 = 4'd2; b1.box_x1 = 4'd5; b1.box_y0 = 4'd1; b1.box_y1 = 4'd3;
        b2.alert = 1'b0; b2.blink_en = 1'b0;
        b2.box_x0 = 4'd0; b2.box_x1 = 4'd8; b2.box_y0 = 4'd0; b2.box_y1 = 4'd4;
        repeat (3) @(negedge clk);
        check("rst_hs1", b1.o_hsync, 1);
        check("rst_vs1", b1.o_vsync, 1);
        check("rst_act1", b1.o_active, 0);
        check("rst_fs1", b1.o_frame_start, 0);
        check("rst_rgb1", {b1.o_red, b1.o_green, b1.o_blue}, 0);
        check("rst_hs2", b2.o_hsync, 0);
        check("rst_vs2", b2.o_vsync, 0);
        rst1_n = 1'b1;
        for (int fi = 0; fi < 7; fi++) begin
            wait_fs(1'b0, gap);
            if (fi > 0) check($sformatf("f%0d_period", fi), gap, 1);
            capture(fi);
            nz = 0;
            for (int k = 0; k < F1; k++) if (c_rgb[k] != 0) nz++;
            check($sformatf("f%0d_box_px", fi), c_rgb[k1(2, 1)], exp_px[fi]);
            check($sformatf("f%0d_box_clks", fi), nz, exp_nz[fi]);
            if (fi == 0) begin
                hsl = 0; vsl = 0; na = 0; nf = 0; bad = 0;
                for (int k = 0; k < F1; k++) begin
                    if (!c_hs[k]) hsl++;
                    if (!c_vs[k]) vsl++;
                    if (c_act[k]) na++;
                    if (c_fs[k]) nf++;
                    if (!c_act[k] && c_rgb[k] != 0) bad++;
                end
                check("hs_low_clks", hsl, 28);
                check("vs_low_clks", vsl, 28);
                check("active_clks", na, 64);
                check("fs_per_frame", nf, 1);
                check("rgb_blank", bad, 0);
                check("act_0_0", c_act[0], 1);
                check("act_7_3", c_act[k1(7, 3)], 1);
                check("act_8_0", c_act[k1(8, 0)], 0);
                check("act_0_4", c_act[k1(0, 4)], 0);
                check("hs_9_0", c_hs[k1(9, 0)], 1);
                check("hs_10_0", c_hs[k1(10, 0)], 0);
                check("hs_11_0", c_hs[k1(11, 0) + 1], 0);
                check("hs_12_0", c_hs[k1(12, 0)], 1);
                check("vs_0_4", c_vs[k1(0, 4)], 1);
                check("vs_0_5", c_vs[k1(0, 5)], 0);
                check("vs_13_5", c_vs[k1(13, 5) + 1], 0);
                check("vs_0_6", c_vs[k1(0, 6)], 1);
                check("px_1_1", c_rgb[k1(1, 1)], 12'h000);
                check("px_5_1", c_rgb[k1(5, 1)], 12'h000);
                check("px_4_2", c_rgb[k1(4, 2) + 1], 12'h0F0);
                check("px_4_3", c_rgb[k1(4, 3)], 12'h000);
            end
        end
        rst2_n = 1'b1;
        wait_fs(1'b1, gap);
        check("p2_first_fs", gap, 1);
        for (int k = 0; k < 98; k++) begin
            if (k > 0) @(negedge clk);
            d_rgb[k] = {b2.o_red, b2.o_green, b2.o_blue};
            d_hs[k]  = b2.o_hsync;
            d_vs[k]  = b2.o_vsync;
        end
        hsl = 0; vsl = 0;
        for (int k = 0; k < 98; k++) begin
            if (d_hs[k]) hsl++;
            if (d_vs[k]) vsl++;
        end
        check("p2_hs_high", hsl, 14);
        check("p2_vs_high", vsl, 14);
        check("p2_hs_9", d_hs[9], 0);
        check("p2_hs_10", d_hs[10], 1);
        check("p2_vs_row5", d_vs[70], 1);
        check("p2_px_0_0", d_rgb[0], 12'h0F0);
        repeat (81) @(negedge clk);
        check("p2_pre_hs", b2.o_hsync, 1);
        check("p2_pre_vs", b2.o_vsync, 1);
        #1 rst2_n = 1'b0;
        #1;
        check("p2_rst_hs", b2.o_hsync, 0);
        check("p2_rst_vs", b2.o_vsync, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        check("p2_restart_fs", b2.o_frame_start, 1);
        check("p2_restart_act", b2.o_active, 1);
        repeat (10) @(negedge clk);
        check("p2_restart_hs", b2.o_hsync, 1);
        repeat (7) @(negedge clk);
        check("p2_pre_rgb", {b2.o_red, b2.o_green, b2.o_blue}, 12'h0F0);
        #1 rst2_n = 1'b0;
        #1;
        check("p2_rst_rgb", {b2.o_red, b2.o_green, b2.o_blue}, 0);
        check("p2_rst_act", b2.o_active, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        check("p2_restart2_fs", b2.o_frame_start, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_overlay.md
Name: vga_timing_overlay

Overview:
- Parametrised successor to the fixed 640x480 VGA generator: configurable H/V timing, sync polarity and pixel-clock division.
- Uses an internal clock enable instead of a PLL.
- Draws one programmable rectangular status box whose colour follows an alert input, with an optional blink mode.
- Sits between the crash-detection logic (alert, box geometry) and the board VGA DAC pins.

Parameters:
- CW, 4: bits per colour channel.
- DIV, 2: system clocks per pixel (>=1); 2 gives 25 MHz pixels from 50 MHz.
- H_ACT, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACT, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- HS_POL, 0; VS_POL, 0: sync active level (0 = active-low).
- XW, 10; YW, 10: counter/coordinate widths; must hold H_TOTAL-1 and V_TOTAL-1.
- OK_RGB, 12'h0F0: box colour when not alerting; {R,G,B} packing, CW bits each.
- ALERT_RGB, 12'hF00: box colour when alerting.
- BG_RGB, 12'h000: active-area colour outside the box.
- BLINK_FRAMES, 30: frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- alert  in  1  crash alert level.
- blink_en  in  1  blink the box while alert=1.
- box_x0  in  XW  box left edge, inclusive.
- box_x1  in  XW  box right edge, exclusive.
- box_y0  in  YW  box top edge, inclusive.
- box_y1  in  YW  box bottom edge, exclusive.
- o_hsync  out  1  horizontal sync.
- o_vsync  out  1  vertical sync.
- o_red  out  CW  red channel.
- o_green  out  CW  green channel.
- o_blue  out  CW  blue channel.
- o_active  out  1  registered display-enable, aligned with RGB.
- o_frame_start  out  1  one-clk pulse on the tick that begins a frame.

Behaviour:
- H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Pixel tick: div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt==DIV-1). With DIV=1, tick is constantly high.
- h_cnt increments on tick and wraps H_TOTAL-1 -> 0.
- v_cnt increments on the tick where h_cnt wraps, and wraps V_TOTAL-1 -> 0.
- Line order is active, front porch, sync, back porch. The same order applies vertically.
- hsync asserted for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC). Output level is HS_POL when asserted, !HS_POL otherwise. vsync follows the same rule using V values and VS_POL.
- active = (h_cnt<H_ACT)&&(v_cnt<V_ACT); pixel x = h_cnt, y = v_cnt.
- Output stage registered, updated only on tick from the current counter values:
  - o_hsync, o_vsync, o_active and RGB are mutually aligned.
  - All lag the counters by exactly one pixel.
- RGB is forced to 0 whenever active=0.
- Shadow registers for box_x0/x1/y0/y1, alert and blink_en:
  - Loaded on the tick where h_cnt==0 && v_cnt==0 (frame start).
  - Input changes mid-frame have no visible effect until the next frame (no tearing).
- o_frame_start = 1 for exactly one clk, registered on that same tick; it is high in the cycle after the shadow load.
- inside = x0<=x<x1 && y0<=y<y1, using shadow values. If x0>=x1 or y0>=y1 the box is empty and never drawn.
- Pixel colour inside the box:
  - shadow alert=0 -> OK_RGB.
  - shadow alert=1, blink off -> ALERT_RGB.
  - shadow alert=1, blink on -> ALERT_RGB when blink_phase=1, BG_RGB when blink_phase=0.
- Pixel colour outside the box: BG_RGB.
- Blink FSM, states SHOW (blink_phase=1) and HIDE (blink_phase=0):
  - frame_cnt counts frame starts 0..BLINK_FRAMES-1. On reaching BLINK_FRAMES-1 at a frame start it wraps to 0 and the state toggles.
  - frame_cnt and blink_phase run continuously regardless of alert.
  - On any frame start where shadow alert transitions 0->1: force SHOW and clear frame_cnt, so the first alert frame is always visible.
- Reset (async assert, synchronous deassert handled at top level):
  - div_cnt, h_cnt, v_cnt, frame_cnt = 0; state SHOW.
  - Shadow registers = 0.
  - o_hsync=!HS_POL, o_vsync=!VS_POL, RGB=0, o_active=0, o_frame_start=0.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the first tick is treated as a frame start (counters at 0) and o_frame_start pulses.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, DIV=2), reset released:
  - hsync low for exactly 4 clks every 28 clks.
  - vsync low for one 28-clk line every 7 lines.
  - o_frame_start period 196 clks.
- Default timing, DIV=2:
  - hsync pulse 192 clks, line 1600 clks, vsync 2 lines, frame 840000 clks.
  - o_active high 640 pixels per line on 480 lines.
- Box (324,604,135,414), alert=0:
  - pixel (324,135) = 0F0, (323,135) = 000, (604,200) = 000.
  - No RGB output while active=0.
- alert toggled 0->1 mid-frame: box stays 0F0 until the next o_frame_start, then F00 from that frame on.
- alert=1, blink_en=1, BLINK_FRAMES=2: box colour sequence over frames is F00, F00, 000, 000, F00…
  - Degenerate box x0=x1: no box pixels in any frame.
- HS_POL=1, VS_POL=1: sync idle low, asserted high.
  - reset_n pulsed low mid-line: all outputs at reset values within the same clk.
  - Timing restarts at h=v=0 with an o_frame_start pulse.
